// File: rtl/dir_meta_arb_pkg.sv
// Shared types and defaults for the directory-meta write arbiter.
// The optional DIR_META_ARB_PRIO0_EN macro is consumed by rr_arbiter.
package dir_meta_arb_pkg;

  localparam int DEF_SET_BITS   = 7;
  localparam int DEF_WAY_BITS   = 4;
  localparam int DEF_STATE_BITS = 2;

  // INVALID coherence state written by the post-reset sweep
  localparam logic [DEF_STATE_BITS-1:0] META_INIT_STATE = 2'b00;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fsm_e;

  typedef struct packed {
    logic [DEF_SET_BITS-1:0]   set;
    logic [DEF_WAY_BITS-1:0]   way;
    logic [DEF_STATE_BITS-1:0] state0;
    logic [DEF_STATE_BITS-1:0] state1;
  } meta_wr_t;

endpackage

// File: rtl/dir_meta_write_arbiter_rr_arbiter.sv
// Round-robin arbiter with its own pointer register.
// With DIR_META_ARB_PRIO0_EN, requester 0 wins outright and leaves the pointer alone.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_valid,
  output logic [PTR_W-1:0]   rr_ptr
);

`ifdef DIR_META_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  int idx_s;
  logic upd_s;
  logic [PTR_W-1:0] ptr_nxt_s;

  // Pick the first valid requester at or after rr_ptr, wrapping around
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;
    idx_s     = 0;
    if (PRIO0 && valid[0]) begin
      grant[0]  = 1'b1;
      any_valid = 1'b1;
    end else begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx_s = int'(rr_ptr) + off;
        if (idx_s >= NUM_REQ) begin
          idx_s = idx_s - NUM_REQ;
        end else begin
          idx_s = idx_s;
        end
        if (!any_valid && valid[idx_s] && !(PRIO0 && (idx_s == 0))) begin
          grant[idx_s] = 1'b1;
          grant_idx    = PTR_W'(idx_s);
          any_valid    = 1'b1;
        end else begin
          any_valid = any_valid;
        end
      end
    end
  end

  assign upd_s     = en && any_valid && !(PRIO0 && grant[0]);
  assign ptr_nxt_s = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + PTR_W'(1);

  // Pointer moves one past the winner on every round-robin grant
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (upd_s) begin
      rr_ptr <= ptr_nxt_s;
    end else begin
      rr_ptr <= rr_ptr;
    end
  end

endmodule

// File: rtl/dir_meta_write_arbiter.sv
// Directory-meta write arbiter: post-reset INIT sweep, then round-robin onto one registered write port.
// Build with DIR_META_ARB_PRIO0_EN to give requester 0 absolute priority.
module dir_meta_write_arbiter
  import dir_meta_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SET_BITS   = DEF_SET_BITS,
  parameter int WAY_BITS   = DEF_WAY_BITS,
  parameter int STATE_BITS = DEF_STATE_BITS,
  parameter logic [STATE_BITS-1:0] INIT_STATE = META_INIT_STATE
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*SET_BITS-1:0]   req_set,
  input  logic [NUM_REQ*WAY_BITS-1:0]   req_way,
  input  logic [NUM_REQ*STATE_BITS-1:0] req_state0,
  input  logic [NUM_REQ*STATE_BITS-1:0] req_state1,
  output logic                          out_valid,
  output logic [SET_BITS-1:0]           out_set,
  output logic [WAY_BITS-1:0]           out_way,
  output logic [STATE_BITS-1:0]         out_state0,
  output logic [STATE_BITS-1:0]         out_state1,
  output logic                          init_done
);

  localparam int CNT_W = SET_BITS + WAY_BITS;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  fsm_e                  state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  run_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic [PTR_W-1:0]      rr_ptr_s;
  logic                  any_valid_s;
  int                    gsel_s;
  logic                  nxt_valid_s;
  logic [SET_BITS-1:0]   nxt_set_s;
  logic [WAY_BITS-1:0]   nxt_way_s;
  logic [STATE_BITS-1:0] nxt_state0_s;
  logic [STATE_BITS-1:0] nxt_state1_s;

  assign run_s     = (state_r == ST_RUN);
  assign init_done = run_s;
  assign req_ready = run_s ? grant_s : '0;
  assign gsel_s    = int'(grant_idx_s);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .clock     (clock),
    .reset     (reset),
    .en        (run_s),
    .valid     (req_valid),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_valid (any_valid_s),
    .rr_ptr    (rr_ptr_s)
  );

  // Next output-stage contents: sweep entry in INIT, granted request in RUN
  always_comb begin
    nxt_valid_s  = 1'b0;
    nxt_set_s    = out_set;
    nxt_way_s    = out_way;
    nxt_state0_s = out_state0;
    nxt_state1_s = out_state1;
    case (state_r)
      ST_INIT: begin
        nxt_valid_s  = 1'b1;
        nxt_set_s    = cnt_r[CNT_W-1:WAY_BITS];
        nxt_way_s    = cnt_r[WAY_BITS-1:0];
        nxt_state0_s = INIT_STATE;
        nxt_state1_s = INIT_STATE;
      end
      ST_RUN: begin
        if (any_valid_s) begin
          nxt_valid_s  = 1'b1;
          nxt_set_s    = req_set[gsel_s*SET_BITS +: SET_BITS];
          nxt_way_s    = req_way[gsel_s*WAY_BITS +: WAY_BITS];
          nxt_state0_s = req_state0[gsel_s*STATE_BITS +: STATE_BITS];
          nxt_state1_s = req_state1[gsel_s*STATE_BITS +: STATE_BITS];
        end else begin
          nxt_valid_s = 1'b0;
        end
      end
      default: nxt_valid_s = 1'b0;
    endcase
  end

  // Sweep counter and INIT->RUN transition; RUN only leaves through reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INIT;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        ST_INIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == '1) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_INIT;
          end
        end
        ST_RUN:  state_r <= ST_RUN;
        default: state_r <= ST_INIT;
      endcase
    end
  end

  // Output register feeding the meta SRAM write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_set    <= '0;
      out_way    <= '0;
      out_state0 <= '0;
      out_state1 <= '0;
    end else begin
      out_valid  <= nxt_valid_s;
      out_set    <= nxt_set_s;
      out_way    <= nxt_way_s;
      out_state0 <= nxt_state0_s;
      out_state1 <= nxt_state1_s;
    end
  end

endmodule

// File: tb/tb_dir_meta_write_arbiter.sv
// Directed table-driven bench for dir_meta_write_arbiter (default build or DIR_META_ARB_PRIO0_EN).
module tb_dir_meta_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [3:0]  req_ready;
  logic [27:0] req_set = '0;
  logic [15:0] req_way = '0;
  logic [7:0]  req_state0 = '0;
  logic [7:0]  req_state1 = '0;
  logic        out_valid;
  logic [6:0]  out_set;
  logic [3:0]  out_way;
  logic [1:0]  out_state0;
  logic [1:0]  out_state1;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  dir_meta_write_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_set    (req_set),
    .req_way    (req_way),
    .req_state0 (req_state0),
    .req_state1 (req_state1),
    .out_valid  (out_valid),
    .out_set    (out_set),
    .out_way    (out_way),
    .out_state0 (out_state0),
    .out_state1 (out_state1),
    .init_done  (init_done)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] exp_set(input int i);
    return 7'h20 + 7'(i);
  endfunction
  function automatic logic [3:0] exp_way(input int i);
    return 4'(i + 9);
  endfunction
  function automatic logic [1:0] exp_s0(input int i);
    return 2'(i);
  endfunction
  function automatic logic [1:0] exp_s1(input int i);
    return 2'(3 - i);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_fields();
    for (int i = 0; i < 4; i++) begin
      req_set[i*7 +: 7]    = exp_set(i);
      req_way[i*4 +: 4]    = exp_way(i);
      req_state0[i*2 +: 2] = exp_s0(i);
      req_state1[i*2 +: 2] = exp_s1(i);
    end
  endtask

  task automatic run_sweep(input string tag);
    req_valid = 4'b1111;
    for (int i = 0; i < 2048; i++) begin
      tick();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_set"},   32'(out_set),   32'(i[10:4]));
      chk({tag, "_way"},   32'(out_way),   32'(i[3:0]));
      chk({tag, "_st"},    32'({out_state0, out_state1}), 32'd0);
      chk({tag, "_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_done"},  32'(init_done), (i == 2047) ? 32'd1 : 32'd0);
      if (i == 2046) req_valid = 4'b0000;
    end
  endtask

  task automatic run_table();
    int g;
    for (int k = 0; k < NV; k++) begin
      req_valid = vecs[k].valid;
      #1;
      chk("grant", 32'(req_ready), 32'(vecs[k].ready));
      tick();
      chk("tbl_out_valid", 32'(out_valid), (vecs[k].ready != 4'b0000) ? 32'd1 : 32'd0);
      g = -1;
      for (int j = 0; j < 4; j++) begin
        if (vecs[k].ready[j]) g = j;
      end
      if (g >= 0) begin
        chk("tbl_set", 32'(out_set), 32'(exp_set(g)));
        chk("tbl_way", 32'(out_way), 32'(exp_way(g)));
        chk("tbl_st0", 32'(out_state0), 32'(exp_s0(g)));
        chk("tbl_st1", 32'(out_state1), 32'(exp_s1(g)));
      end
    end
  endtask

  initial begin
`ifdef DIR_META_ARB_PRIO0_EN
    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0001};
    vecs[2]  = '{4'b1110, 4'b0010};
    vecs[3]  = '{4'b1110, 4'b0100};
    vecs[4]  = '{4'b1110, 4'b1000};
    vecs[5]  = '{4'b1110, 4'b0010};
    vecs[6]  = '{4'b1111, 4'b0001};
    vecs[7]  = '{4'b1110, 4'b0100};
    vecs[8]  = '{4'b0000, 4'b0000};
    vecs[9]  = '{4'b0011, 4'b0001};
    vecs[10] = '{4'b0010, 4'b0010};
    vecs[11] = '{4'b1001, 4'b0001};
    vecs[12] = '{4'b1000, 4'b1000};
    vecs[13] = '{4'b0100, 4'b0100};
`else
    vecs[0]  = '{4'b1111, 4'b0001};
    vecs[1]  = '{4'b1111, 4'b0010};
    vecs[2]  = '{4'b1111, 4'b0100};
    vecs[3]  = '{4'b1111, 4'b1000};
    vecs[4]  = '{4'b1111, 4'b0001};
    vecs[5]  = '{4'b0000, 4'b0000};
    vecs[6]  = '{4'b0001, 4'b0001};
    vecs[7]  = '{4'b1000, 4'b1000};
    vecs[8]  = '{4'b0110, 4'b0010};
    vecs[9]  = '{4'b0011, 4'b0001};
    vecs[10] = '{4'b0011, 4'b0010};
    vecs[11] = '{4'b1100, 4'b0100};
    vecs[12] = '{4'b0011, 4'b0001};
    vecs[13] = '{4'b0011, 4'b0010};
`endif
    load_fields();

    // Held in reset with requests pending: everything quiet
    req_valid = 4'b1111;
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fields", 32'({out_set, out_way, out_state0, out_state1}), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);

    reset = 1'b1;
    run_sweep("sweep");

    run_table();

    // Lone requester 2 with specific fields
    req_set[14 +: 7]   = 7'h15;
    req_way[8 +: 4]    = 4'd3;
    req_state0[4 +: 2] = 2'd2;
    req_state1[4 +: 2] = 2'd1;
    req_valid = 4'b0100;
    #1;
    chk("r2_ready", 32'(req_ready), 32'h4);
    tick();
    chk("r2_valid", 32'(out_valid), 32'd1);
    chk("r2_set", 32'(out_set), 32'h15);
    chk("r2_way", 32'(out_way), 32'd3);
    chk("r2_st0", 32'(out_state0), 32'd2);
    chk("r2_st1", 32'(out_state1), 32'd1);
    req_valid = 4'b0000;
    tick();
    chk("r2_single", 32'(out_valid), 32'd0);
    load_fields();

    // Reset mid-sweep clears immediately and the sweep restarts from 0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 500; i++) tick();
    chk("pre_rst_set", 32'(out_set), 32'd31);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_fields", 32'({out_set, out_way, out_state0, out_state1}), 32'd0);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    tick();
    reset = 1'b1;
    run_sweep("resweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dir_meta_write_arbiter.md
Name: dir_meta_write_arbiter

Overview:
- Shares the single directory-meta write pipeline (set, way, 2×state) among NUM_REQ requesters: MSHRs, sink-C and the prefetch path.
- After reset it sweeps every (set, way) to INIT_STATE. It then grants round-robin and drives one registered output stage.
- That stage feeds the meta SRAM write port, which has no backpressure.

Parameters:
- NUM_REQ, 4, number of requesters.
- SET_BITS, 7, set index width.
- WAY_BITS, 4, way index width.
- STATE_BITS, 2, width of each state field.
- INIT_STATE, 2'b00, state value written during the init sweep (INVALID).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester grant; a write is accepted when valid&ready.
- req_set  in  NUM_REQ*SET_BITS  packed, requester i at [i*SET_BITS +: SET_BITS].
- req_way  in  NUM_REQ*WAY_BITS  packed.
- req_state0  in  NUM_REQ*STATE_BITS  packed.
- req_state1  in  NUM_REQ*STATE_BITS  packed.
- out_valid  out  1  meta write strobe.
- out_set  out  SET_BITS  write set.
- out_way  out  WAY_BITS  write way.
- out_state0  out  STATE_BITS  data_0 state.
- out_state1  out  STATE_BITS  data_1 state.
- init_done  out  1  high once the sweep is complete.

Behaviour:
- Reset (async assert, sync release):
  - FSM=INIT, sweep counter=0, rr_ptr=0.
  - out_valid=0; out_set/out_way/out_state0/out_state1=0.
  - init_done=0; req_ready=0.
- FSM INIT:
  - req_ready forced to 0.
  - Each cycle the output register loads valid=1, set=cnt[SET_BITS+WAY_BITS-1:WAY_BITS], way=cnt[WAY_BITS-1:0], state0=state1=INIT_STATE.
  - cnt then increments.
  - When cnt is all-ones and loads, the next state is RUN. The sweep takes exactly 2^(SET_BITS+WAY_BITS) cycles (2048 by default).
- FSM RUN:
  - init_done=1.
  - Grant goes to the first valid requester at or after rr_ptr, searching upward with wrap-around. req_ready is one-hot on that index; all others are 0.
  - req_ready depends combinationally on req_valid and rr_ptr only. A requester must not make valid depend on ready.
  - On grant to index g: rr_ptr <= (g+1) mod NUM_REQ, and the output register loads that requester's fields with valid=1.
  - With no request valid: out_valid <= 0 and rr_ptr is held.
- Latency and throughput:
  - Latency is exactly 1 cycle from accept to out_valid.
  - Throughput is 1 write per cycle; out_valid is high exactly one cycle per accepted request.
- No output backpressure. out_* are registered, and their fields are stable only while out_valid=1.
- RUN is terminal; only reset returns the FSM to INIT.
- Reset asserted mid-sweep or mid-run: all state clears immediately and the sweep restarts from 0. In-flight grants are dropped; requesters re-present them.
- Simultaneous same-set writes from two requesters are serialized in grant order. The later write wins in the array; the block does not merge them.

Optional Feature:
- Macro DIR_META_ARB_PRIO0_EN.
- Defined: requester 0 (sink-C release path) has absolute priority. When req_valid[0]=1 it is granted regardless of rr_ptr, and rr_ptr is unchanged. Requesters 1..NUM_REQ-1 round-robin among themselves when req_valid[0]=0.
- Undefined: pure round-robin over all NUM_REQ requesters as above.

Decomposition:
- Package dir_meta_arb_pkg holds:
  - FSM enum {ST_INIT, ST_RUN};
  - default widths SET_BITS/WAY_BITS/STATE_BITS;
  - INIT_STATE constant;
  - packed struct meta_wr_t {set, way, state0, state1}.
- One sub-module, rr_arbiter: parameterized NUM_REQ. It takes valid and rr_ptr and returns a one-hot grant, a grant index and any_valid, plus the pointer-update register.
- The top holds the FSM, sweep counter and output register.

Test Plan:
- Reset released, no requests:
  - out_valid=1 for 2048 consecutive cycles, (set, way) running 0/0 .. 127/15 with state=0.
  - init_done rises on cycle 2049.
  - req_ready=0 throughout the sweep.
- After init, req_valid=4'b1111 held:
  - grants cycle 0,1,2,3,0,…
  - out_set follows each requester's set one cycle later, with no gaps.
- After init, only req 2 valid with set=0x15, way=3, state0=2, state1=1:
  - req_ready=4'b0100;
  - next cycle out_valid=1, out_set=0x15, out_way=3, out_state0=2, out_state1=1.
- rr_ptr=3 and req_valid=4'b0011: grant goes to 0, then rr_ptr=1 and the next grant goes to 1 (wrap-around).
- Reset pulled low at sweep cycle 500: outputs are 0 immediately; after release the sweep restarts at set 0, way 0 and again lasts 2048 cycles.
- With DIR_META_ARB_PRIO0_EN and req_valid=4'b1111 held: req 0 is granted every cycle and reqs 1–3 are never granted. Dropping req 0 gives the sequence 1,2,3,1.
